// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
//
// Shared definitions for the 4x4 keypad scanner:
//   - KEY_CANCEL / KEY_ENTER codes for the '*' and '#' keys, matching the
//     code space decoded by the vault combination logic
//   - scan_state_e, the scanner state machine encoding
//   - keymap(), which converts a (row, column) position into a 4-bit key code
// ---------------------------------------------------------------------------
package keypad_pkg;

  localparam logic [3:0] KEY_CANCEL = 4'hF;
  localparam logic [3:0] KEY_ENTER  = 4'hE;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } scan_state_e;

  // Physical layout of the keypad:
  //   r0: 1 2 3 A
  //   r1: 4 5 6 B
  //   r2: 7 8 9 C
  //   r3: * 0 # D
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_CANCEL;
      4'hD: code = 4'h0;
      4'hE: code = KEY_ENTER;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// ---------------------------------------------------------------------------
// row_sync
//
// Two-flop synchronizer for the four asynchronous, active-low row inputs.
// Resets to all-ones so that a reset looks like "no row pulled low".
//
// Ports:
//   clk         in  1  system clock
//   reset       in  1  synchronous, active-high reset
//   row_n_in    in  4  raw row sense lines (asynchronous, active-low)
//   row_n_sync  out 4  row sense lines synchronized to clk
// ---------------------------------------------------------------------------
module row_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n_in,
  output logic [3:0] row_n_sync
);

  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  always_comb begin
    meta_d = row_n_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign row_n_sync = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad one column at a time, debounces presses and
// releases, and presents one key code per press with n-key lockout.
//
// Parameters:
//   SCAN_DIV          clock cycles each column is driven (>= 4)
//   DEBOUNCE_SAMPLES  consecutive identical samples to accept press/release (>= 2)
//
// Ports:
//   clk        in  1  system clock
//   reset      in  1  synchronous, active-high reset
//   col_n      out 4  column drive, active-low, exactly one bit low
//   row_n      in  4  row sense, active-low, asynchronous
//   key_valid  out 1  high while a debounced key is held
//   key_code   out 4  code of the most recently accepted key
//
// Build option:
//   KEYPAD_GHOST_REJECT_EN  when defined, a sample with more than one row low
//                           is treated as "no hit"; otherwise the lowest-index
//                           low row is used.
// ---------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV         = 50000,
  parameter int unsigned DEBOUNCE_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W   = $clog2(DEBOUNCE_SAMPLES + 1);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_SAMPLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  logic [3:0] row_n_sync;

  row_sync u_row_sync (
    .clk        (clk),
    .reset      (reset),
    .row_n_in   (row_n),
    .row_n_sync (row_n_sync)
  );

  scan_state_e        state_q,     state_d;
  logic [DWELL_W-1:0] dwell_q,     dwell_d;
  logic [1:0]         col_q,       col_d;
  logic [CNT_W-1:0]   match_q,     match_d;
  logic [CNT_W-1:0]   release_q,   release_d;
  logic [1:0]         hit_row_q,   hit_row_d;
  logic [3:0]         key_code_q,  key_code_d;
  logic               key_valid_q, key_valid_d;

  logic [3:0] row_low;
  logic       sample_hit;
  logic [1:0] sample_row;
  logic       sample_match;
  logic       dwell_end;

  // Row decode: pick the lowest-index low row. With ghost rejection enabled,
  // several rows low at once is treated as an unreliable sample.
  always_comb begin
    row_low    = ~row_n_sync;
    sample_row = 2'd3;
    if (row_low[0]) begin
      sample_row = 2'd0;
    end else if (row_low[1]) begin
      sample_row = 2'd1;
    end else if (row_low[2]) begin
      sample_row = 2'd2;
    end
`ifdef KEYPAD_GHOST_REJECT_EN
    sample_hit = (row_low != 4'h0) && ((row_low & (row_low - 4'd1)) == 4'h0);
`else
    sample_hit = (row_low != 4'h0);
`endif
    sample_match = sample_hit && (sample_row == hit_row_q);
  end

  // Dwell timer: the sample is the synchronized rows on the last dwell cycle.
  always_comb begin
    dwell_end = (dwell_q == DWELL_LAST);
    dwell_d   = dwell_end ? '0 : dwell_q + DWELL_W'(1);
  end

  // Scanner FSM. Every decision is made only on the last cycle of a dwell,
  // so the column register, and therefore col_n, only ever changes on the
  // first cycle of the following dwell.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    match_d    = match_q;
    release_d  = release_q;
    hit_row_d  = hit_row_q;
    key_code_d = key_code_q;

    if (dwell_end) begin
      case (state_q)
        SCAN: begin
          if (sample_hit) begin
            // The first hit already counts as one matching sample.
            state_d   = DEBOUNCE;
            hit_row_d = sample_row;
            match_d   = CNT_ONE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end

        DEBOUNCE: begin
          if (sample_match) begin
            if (match_q == CNT_LAST) begin
              state_d    = PRESSED;
              key_code_d = keymap(hit_row_q, col_q);
              match_d    = '0;
              release_d  = '0;
            end else begin
              match_d = match_q + CNT_ONE;
            end
          end else begin
            state_d = SCAN;
            col_d   = col_q + 2'd1;
            match_d = '0;
          end
        end

        PRESSED: begin
          // Column stays parked on the held key; any other sample, including
          // a different row, counts toward release.
          if (sample_match) begin
            release_d = '0;
          end else if (release_q == CNT_LAST) begin
            state_d   = SCAN;
            col_d     = col_q + 2'd1;
            release_d = '0;
          end else begin
            release_d = release_q + CNT_ONE;
          end
        end

        default: begin
          state_d   = SCAN;
          match_d   = '0;
          release_d = '0;
        end
      endcase
    end

    // Valid rises one cycle after the code loads (state_q is already PRESSED)
    // and drops on the same edge the release completes and the column moves.
    key_valid_d = (state_q == PRESSED) && (state_d == PRESSED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      dwell_q     <= '0;
      col_q       <= 2'd0;
      match_q     <= '0;
      release_q   <= '0;
      hit_row_q   <= 2'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      col_q       <= col_d;
      match_q     <= match_d;
      release_q   <= release_d;
      hit_row_q   <= hit_row_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  // One-hot-low decode of a registered index: exactly one column is low.
  assign col_n     = ~(4'b0001 << col_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//
// Self-checking bench for keypad_scanner (SCAN_DIV=8, DEBOUNCE_SAMPLES=3).
// A behavioural keypad model pulls a row low whenever a pressed key's column
// is driven. Stimulus pushes the expected code of every accepted press into a
// queue; an independent monitor pops it on each key_valid rising edge.
// Define KEYPAD_GHOST_REJECT_EN for both bench and RTL to test that build.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       key_valid;
  logic [3:0] key_code;

  logic [15:0] pressed;
  logic [3:0]  exp_q[$];
  int          checks;
  int          failures;

  keypad_scanner #(
    .SCAN_DIV         (8),
    .DEBOUNCE_SAMPLES (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keypad matrix: key (r,c) shorts row r to column c while pressed.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  // Compares one observed value against its required value.
  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Presses or releases one key of the matrix.
  task automatic applyStimulus(input int r, input int c, input logic down);
    pressed[r*4+c] = down;
  endtask

  // Waits (bounded) for key_valid to reach a level; a timeout is a failure.
  task automatic waitValid(input logic level, input int budget, input string name);
    int n;
    n = 0;
    while (key_valid !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (key_valid !== level) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout key_valid=%b required=%b", name, key_valid, level);
    end
  endtask

  // Waits (bounded) for the start of a dwell on the given column.
  task automatic waitColStart(input logic [3:0] target, input string name);
    int n;
    n = 0;
    while (col_n === target && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (col_n !== target && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (col_n !== target) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout col_n=%b required=%b", name, col_n, target);
    end
  endtask

  // Monitor: on every key_valid rise, the code must match the next expected
  // entry and must already have been present on the previous cycle.
  initial begin
    logic       prev_valid;
    logic [3:0] prev_code;
    logic [3:0] exp_code;
    prev_valid = 1'b0;
    prev_code  = 4'h0;
    forever begin
      @(negedge clk);
      if (key_valid === 1'b1 && prev_valid === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_press actual_code=%h required=no key_valid", key_code);
        end else begin
          exp_code = exp_q.pop_front();
          checkOutput("press_code", {4'h0, key_code}, {4'h0, exp_code});
          checkOutput("code_leads_valid", {4'h0, prev_code}, {4'h0, exp_code});
        end
      end
      prev_valid = key_valid;
      prev_code  = key_code;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] exp_col;
    checks   = 0;
    failures = 0;
    pressed  = 16'h0;
    reset    = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("reset_col_n", {4'h0, col_n}, 8'h0E);
    checkOutput("reset_key_valid", {7'h0, key_valid}, 8'h00);
    checkOutput("reset_key_code", {4'h0, key_code}, 8'h00);
    reset = 1'b0;

    // Column rotation: one column per 8-cycle dwell.
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k < 8)       exp_col = 4'b1110;
      else if (k < 16) exp_col = 4'b1101;
      else if (k < 24) exp_col = 4'b1011;
      else if (k < 32) exp_col = 4'b0111;
      else             exp_col = 4'b1110;
      if (k == 1 || k == 7 || k == 8 || k == 16 || k == 24 || k == 32)
        checkOutput("rotate_col_n", {4'h0, col_n}, {4'h0, exp_col});
    end

    // Key '6' at row1/col2, then release.
    exp_q.push_back(4'h6);
    applyStimulus(1, 2, 1'b1);
    waitValid(1'b1, 200, "press6_rise");
    applyStimulus(1, 2, 1'b0);
    waitValid(1'b0, 100, "press6_fall");
    checkOutput("release_col_advance", {4'h0, col_n}, 8'h07);
    checkOutput("code_after_release", {4'h0, key_code}, 8'h06);

    // Bounce on '1' (row0/col0): hit, no-hit, then steady.
    waitColStart(4'b1110, "bounce_col0");
    applyStimulus(0, 0, 1'b1);
    repeat (8) @(negedge clk);
    applyStimulus(0, 0, 1'b0);
    repeat (8) @(negedge clk);
    checkOutput("bounce_no_valid", {7'h0, key_valid}, 8'h00);
    exp_q.push_back(4'h1);
    applyStimulus(0, 0, 1'b1);
    waitValid(1'b1, 200, "bounce_rise");
    applyStimulus(0, 0, 1'b0);
    waitValid(1'b0, 100, "bounce_fall");

    // '*' then '#'.
    exp_q.push_back(4'hF);
    applyStimulus(3, 0, 1'b1);
    waitValid(1'b1, 200, "star_rise");
    applyStimulus(3, 0, 1'b0);
    waitValid(1'b0, 100, "star_fall");
    exp_q.push_back(4'hE);
    applyStimulus(3, 2, 1'b1);
    waitValid(1'b1, 200, "hash_rise");
    applyStimulus(3, 2, 1'b0);
    waitValid(1'b0, 100, "hash_fall");
    checkOutput("hash_code_held", {4'h0, key_code}, 8'h0E);

    // Rows 0 and 2 low together on col1.
    applyStimulus(0, 1, 1'b1);
    applyStimulus(2, 1, 1'b1);
`ifdef KEYPAD_GHOST_REJECT_EN
    repeat (200) @(negedge clk);
    checkOutput("ghost_no_valid", {7'h0, key_valid}, 8'h00);
    applyStimulus(0, 1, 1'b0);
    applyStimulus(2, 1, 1'b0);
`else
    exp_q.push_back(4'h2);
    waitValid(1'b1, 200, "ghost_rise");
    applyStimulus(0, 1, 1'b0);
    applyStimulus(2, 1, 1'b0);
    waitValid(1'b0, 100, "ghost_fall");
`endif
    repeat (10) @(negedge clk);

    // Reset while a key is held, then re-debounce from SCAN.
    exp_q.push_back(4'h6);
    applyStimulus(1, 2, 1'b1);
    waitValid(1'b1, 200, "rst_press_rise");
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_key_valid", {7'h0, key_valid}, 8'h00);
    checkOutput("rst_col_n", {4'h0, col_n}, 8'h0E);
    checkOutput("rst_key_code", {4'h0, key_code}, 8'h00);
    exp_q.push_back(4'h6);
    reset = 1'b0;
    waitValid(1'b1, 200, "rst_repress_rise");
    applyStimulus(1, 2, 1'b0);
    waitValid(1'b0, 100, "rst_repress_fall");

    repeat (20) @(negedge clk);
    checkOutput("scoreboard_drained", 8'(exp_q.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
